// File: rtl/instr_fetch_unit.sv
// MIPS32 instruction-fetch stage: owns the PC, runs a single-outstanding
// request/response fetch to instruction memory and holds one IF/ID entry.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        drop;
    logic        slot_free;
    logic        req_fire;
    logic        rsp_fire;
    logic        load;
    logic        consume;

    // A request only issues once the IF/ID slot is free, so a response never
    // lands on an occupied entry.
    assign slot_free      = !if_valid || id_ready;
    assign imem_req_valid = (state == S_REQ) && slot_free;
    assign imem_addr      = pc;
    assign pc_plus4       = pc + 32'd4;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = (state == S_WAIT) && imem_rsp_valid;
    assign load           = rsp_fire && !drop && !redirect_valid;
    assign consume        = if_valid && id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET;
            drop  <= 1'b0;
        end else begin
            case (state)
                S_RESET: state <= S_REQ;
                S_REQ: begin
                    if (req_fire) begin
                        state <= S_WAIT;
                        // a redirect on the accept edge orphans the old-PC fetch
                        drop  <= redirect_valid;
                    end
                end
                S_WAIT: begin
                    if (rsp_fire) begin
                        state <= S_REQ;
                        drop  <= 1'b0;
                    end else if (redirect_valid) begin
                        drop  <= 1'b1;
                    end
                end
                default: state <= S_RESET;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            if_valid     <= 1'b0;
            if_instr     <= NOP_INSTR;
            if_pc        <= 32'h0;
            if_pc4       <= 32'h0;
            misalign_err <= 1'b0;
            fetch_count  <= 32'h0;
        end else begin
            if (redirect_valid) begin
                pc <= {redirect_target[31:2], 2'b00};
            end else if (load) begin
                pc <= pc_plus4;
            end

            if (redirect_valid) begin
                if_valid <= 1'b0;
                if_instr <= NOP_INSTR;
            end else if (load) begin
                if_valid <= 1'b1;
                if_instr <= imem_rsp_data;
                if_pc    <= pc;
                if_pc4   <= pc_plus4;
            end else if (consume) begin
                if_valid <= 1'b0;
                if_instr <= NOP_INSTR;
            end

            // squashed entries never count as delivered
            if (consume && !redirect_valid) begin
                fetch_count <= fetch_count + 32'd1;
            end

            if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
                misalign_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the delivered instruction stream.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        misalign_err;
    logic [31:0] fetch_count;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // stimulus knobs
    logic        drv_ready, drv_idr, drv_redir;
    logic [31:0] drv_tgt;
    int          drv_lat;
    bit          redir_on_rsp, redir_on_acc, fired;

    // memory and reference model state
    bit          pend, sq;
    logic [31:0] pend_addr;
    int          pend_dly;
    logic [31:0] exp_pc, exp_count;
    logic        exp_mis;
    bit          last_acc, last_new, got;
    logic [31:0] last_acc_addr, last_new_pc;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, observe the request before the edge,
    // then compare the registered outputs just after it.
    task automatic cycle();
        logic        pre_valid, acc, rsp_live, exp_load, newent, held, redir;
        logic [31:0] h_pc, h_instr;
        @(negedge clk);
        rsp_live = 1'b0;
        if (pend && pend_dly == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(pend_addr);
            rsp_live       = !sq;
            pend           = 1'b0;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            if (pend) pend_dly--;
        end
        imem_req_ready  = drv_ready;
        id_ready        = drv_idr;
        redirect_valid  = drv_redir || (redir_on_rsp && imem_rsp_valid);
        redirect_target = drv_tgt;
        #1;
        acc = imem_req_valid && imem_req_ready;
        if (redir_on_acc && acc) redirect_valid = 1'b1;
        if (redirect_valid && !drv_redir) fired = 1'b1;
        redir     = redirect_valid;
        pre_valid = if_valid;
        h_pc      = if_pc;
        h_instr   = if_instr;
        if (if_valid && !id_ready) check("stall_no_req", imem_req_valid, 0);
        last_acc = acc;
        if (acc) begin
            check("fetch_addr", imem_addr, exp_pc);
            check("single_outstanding", pend, 0);
            pend          = 1'b1;
            pend_addr     = imem_addr;
            pend_dly      = drv_lat - 1;
            sq            = redir;
            last_acc_addr = imem_addr;
        end else if (pend && redir) begin
            sq = 1'b1;
        end
        @(posedge clk);
        #1;
        exp_load = rsp_live && !redir;
        if (pre_valid && id_ready && !redir) exp_count++;
        if (redir) begin
            exp_pc = {redirect_target[31:2], 2'b00};
            if (redirect_target[1:0] != 2'b00) exp_mis = 1'b1;
            check("squash", if_valid, 0);
        end
        held   = pre_valid && !id_ready && !redir;
        newent = if_valid && !held;
        check("deliver", newent, exp_load);
        last_new = newent;
        if (newent) begin
            check("if_pc", if_pc, exp_pc);
            check("if_instr", if_instr, memfn(exp_pc));
            check("if_pc4", if_pc4, exp_pc + 32'd4);
            last_new_pc = if_pc;
            exp_pc      = exp_pc + 32'd4;
        end
        if (held) begin
            check("hold_valid", if_valid, 1);
            check("hold_instr", if_instr, h_instr);
            check("hold_pc", if_pc, h_pc);
        end
        if (!if_valid) check("nop_when_invalid", if_instr, NOP_INSTR);
        check("fetch_count", fetch_count, exp_count);
        check("misalign", misalign_err, exp_mis);
    endtask

    task automatic run_until_new(input int bound);
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            cycle();
            got = last_new;
        end
    endtask

    task automatic run_until_acc(input int bound);
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            cycle();
            got = last_acc;
        end
    endtask

    // Asynchronous reset mid-cycle, followed by a stale response pulse that
    // must be ignored both in S_RESET and in S_REQ.
    task automatic do_reset();
        #1;
        imem_req_ready = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        rst_n          = 1'b0;
        #1;
        check("rst_if_valid", if_valid, 0);
        check("rst_if_instr", if_instr, NOP_INSTR);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_pc4", if_pc4, 0);
        check("rst_misalign", misalign_err, 0);
        check("rst_fetch_count", fetch_count, 0);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_addr", imem_addr, RESET_PC);
        pend      = 1'b0;
        sq        = 1'b1;
        exp_pc    = RESET_PC;
        exp_count = 32'h0;
        exp_mis   = 1'b0;
        @(negedge clk);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_if_valid", if_valid, 0);
        check("rel_req_valid", imem_req_valid, 1);
        check("rel_addr", imem_addr, RESET_PC);
        pend      = 1'b1;
        pend_dly  = 0;
        pend_addr = 32'hDEAD_BEE0;
    endtask

    initial begin
        logic [31:0] t;
        int          r;
        rst_n = 1'b1;
        imem_req_ready = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        drv_ready = 1'b1; drv_idr = 1'b0; drv_redir = 1'b0; drv_tgt = 32'h0; drv_lat = 1;
        redir_on_rsp = 1'b0; redir_on_acc = 1'b0; fired = 1'b0;
        pend = 1'b0; sq = 1'b0; pend_addr = 32'h0; pend_dly = 0;
        exp_pc = RESET_PC; exp_count = 32'h0; exp_mis = 1'b0;
        last_acc = 1'b0; last_new = 1'b0; got = 1'b0;
        last_acc_addr = 32'h0; last_new_pc = 32'h0;

        do_reset();

        // first fetch from address 0 with 1-cycle memory latency
        run_until_new(10);
        check("t1_loaded", got, 1);
        check("t1_instr", if_instr, 32'h2008_0005);
        check("t1_pc", if_pc, 32'h0);
        check("t1_pc4", if_pc4, 32'h4);
        check("t1_next_addr", imem_addr, 32'h4);

        // decode stalls for 5 cycles, then releases the entry
        for (int i = 0; i < 5; i++) cycle();
        check("t2_req_held", imem_req_valid, 0);
        check("t2_instr_stable", if_instr, 32'h2008_0005);
        drv_idr = 1'b1;
        drv_lat = 3;
        cycle();
        check("t2_req_same_cycle", last_acc, 1);
        check("t2_req_addr", last_acc_addr, 32'h4);
        check("t2_fetch_count", fetch_count, 32'h1);

        // redirect while the fetch for 0x8 is outstanding
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            got = last_acc && (last_acc_addr == 32'h8);
        end
        check("t3_acc8", got, 1);
        drv_redir = 1'b1; drv_tgt = 32'h0000_0040;
        cycle();
        drv_redir = 1'b0;
        run_until_new(20);
        check("t3_new", got, 1);
        check("t3_pc40", last_new_pc, 32'h40);

        // redirect coincident with a response
        redir_on_rsp = 1'b1; drv_tgt = 32'h0000_0100; fired = 1'b0;
        for (int i = 0; i < 20 && !fired; i++) cycle();
        redir_on_rsp = 1'b0;
        check("t4_fired_rsp", fired, 1);
        run_until_new(20);
        check("t4_pc100", last_new_pc, 32'h100);

        // redirect coincident with request acceptance
        redir_on_acc = 1'b1; drv_tgt = 32'h0000_0200; fired = 1'b0;
        for (int i = 0; i < 20 && !fired; i++) cycle();
        redir_on_acc = 1'b0;
        check("t5_fired_acc", fired, 1);
        run_until_new(20);
        check("t5_pc200", last_new_pc, 32'h200);

        // misaligned target
        drv_redir = 1'b1; drv_tgt = 32'h0000_0043;
        cycle();
        drv_redir = 1'b0;
        check("t6_misalign", misalign_err, 1);
        check("t6_addr", imem_addr, 32'h40);
        run_until_new(20);
        check("t6_pc40", last_new_pc, 32'h40);

        // PC wrap at the top of the address space
        drv_redir = 1'b1; drv_tgt = 32'hFFFF_FFFC;
        cycle();
        drv_redir = 1'b0;
        run_until_new(20);
        check("t7_pc_top", last_new_pc, 32'hFFFF_FFFC);
        check("t7_pc4_wrap", if_pc4, 32'h0);
        check("t7_addr_wrap", imem_addr, 32'h0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            drv_ready = ($urandom_range(0, 9) < 7);
            drv_idr   = ($urandom_range(0, 9) < 6);
            drv_lat   = $urandom_range(1, 3);
            drv_redir = ($urandom_range(0, 19) == 0);
            t = $urandom;
            r = $urandom_range(0, 7);
            if (r < 6) t[1:0] = 2'b00;
            else if (r == 6) t = 32'hFFFF_FFF8;
            drv_tgt = t;
            cycle();
        end
        drv_redir = 1'b0;

        // reset while waiting for a response
        drv_ready = 1'b1; drv_idr = 1'b1; drv_lat = 3;
        run_until_acc(20);
        check("t8_acc", got, 1);
        do_reset();
        drv_lat = 1;
        run_until_new(20);
        check("t8_new", got, 1);
        check("t8_pc_reset", last_new_pc, RESET_PC);
        check("t8_instr", if_instr, 32'h2008_0005);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction-fetch stage of the MIPS32 datapath. Owns the program counter, issues word fetches to instruction memory through a request/response handshake, and holds the fetched instruction in a single-entry IF/ID output register for the decode stage. It consumes the redirect target produced by the branch-offset adder and jump logic. It produces PC, PC+4 and the instruction word for downstream stages.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
NOP_INSTR, 32'h0000_0000, value driven on if_instr while if_valid=0 (MIPS sll $0,$0,0).

Ports:
Clk  in  1  clock; all state updates on rising edge
Rst  in  1  asynchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_addr  out  32  byte address of the fetch, always word-aligned
imem_rsp_valid  in  1  response data valid; no back-pressure, 1-cycle pulse
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  branch/jump taken; 1-cycle pulse
redirect_target  in  32  new PC from the branch adder / jump logic
id_ready  in  1  decode consumes the IF/ID entry this cycle
if_valid  out  1  IF/ID entry valid
if_instr  out  32  fetched instruction
if_pc  out  32  address of if_instr
if_pc4  out  32  if_pc + 4, registered
misalign_err  out  1  sticky: a redirect target had bits [1:0] != 0
fetch_count  out  32  number of instructions delivered to decode; wraps at 2^32

Behaviour:
- Reset (Rst=0, async): pc=RESET_PC, state=S_RESET, drop=0, if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_pc4=0, misalign_err=0, fetch_count=0, imem_req_valid=0.
- imem_addr = pc at all times. imem_req_valid=1 only in S_REQ with slot_free, where slot_free = !if_valid || id_ready.
- States:
  - S_RESET -> S_REQ unconditionally on the first edge after reset release.
  - S_REQ: if imem_req_valid && imem_req_ready -> S_WAIT; the IF/ID entry drains at this edge (if_valid<=0) when consumed. Otherwise stay in S_REQ.
  - S_WAIT: on imem_rsp_valid with drop=0: if_valid<=1, if_instr<=data, if_pc<=pc, if_pc4<=pc+4, pc<=pc+4, -> S_REQ. With drop=1: discard the data, drop<=0, -> S_REQ.
- At most one request is outstanding. The response arrives at least 1 cycle after acceptance. Because the request issues only when the slot frees, the slot is always empty when the response lands. Peak throughput is 1 instruction per 2 cycles.
- Consumption: if_valid && id_ready and no new load that edge -> if_valid<=0, if_instr<=NOP_INSTR. fetch_count increments on every edge where if_valid && id_ready.
- Redirect (highest priority over all of the above):
  - pc<={redirect_target[31:2],2'b00}; if_valid<=0 (squash); misalign_err<=1 if target[1:0]!=0.
  - In S_REQ with the request not accepted: stay in S_REQ. The next cycle's address is the new pc; a change of imem_addr while the request is unaccepted is permitted only on redirect.
  - In S_REQ with the request accepted the same cycle: -> S_WAIT with drop<=1, because the old-PC fetch is in flight.
  - In S_WAIT with no response: drop<=1, stay in S_WAIT.
  - In S_WAIT with the response arriving the same cycle: discard it, drop<=0, -> S_REQ.
  - A squashed entry is not counted in fetch_count, even if id_ready=1 that cycle.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0), with no flag.
- Reset asserted mid-transaction: everything returns to reset values immediately, and any later response is ignored in S_RESET/S_REQ.
- imem_rsp_valid outside S_WAIT is ignored.

Test Plan:
- Reset then memory with ready=1 and 1-cycle latency returning 32'h2008_0005 at 0x0 -> if_valid=1, if_instr=32'h2008_0005, if_pc=0, if_pc4=4; next request addr=0x4.
- Hold id_ready=0 with if_valid=1 for 5 cycles -> imem_req_valid stays 0 and the outputs stay stable. Raise id_ready -> request for the next PC issues the same cycle, and fetch_count increments by 1.
- Redirect to 0x0000_0040 while in S_WAIT for 0x8 -> response for 0x8 discarded, if_valid stays 0, next request addr=0x40, then if_pc=0x40.
- Redirect coincident with imem_rsp_valid and with request acceptance, in separate runs -> no instruction from the old PC ever reaches if_valid=1.
- Redirect to 0x0000_0043 -> misalign_err=1 (sticky until reset), fetch addr=0x40.
- Start from pc=32'hFFFF_FFFC with a fetch -> if_pc4=0 and the next addr=0. Assert Rst mid-S_WAIT -> outputs reset immediately and the next request addr=RESET_PC.
